// File: rtl/comm_pkg.sv
// Shared state encoding, default parameters and width helper for the Pico-link
// serial audio receiver.
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1
  } rx_state_e;

  localparam int DEFAULT_DATA_W      = 16;
  localparam int DEFAULT_CHANNELS    = 2;
  localparam int DEFAULT_FIFO_DEPTH  = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/comm_rx_fifo.sv
// Small ring-buffer FIFO with full/empty flags; a depth of 1 degenerates into a
// single holding register that still accepts a push alongside a same-cycle pop.
module comm_rx_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    // A full buffer can still take a word when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spi_audio_rx.sv
// Multi-channel SPI audio receiver: synchronises the Pico bus, deserialises MSB-first
// words tagged with a channel index and buffers them. SPI_AUDIO_RX_FIFO_EN selects the
// FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module spi_audio_rx
  import comm_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CHANNELS     = DEFAULT_CHANNELS,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
  localparam int CH_W        = ch_width(CHANNELS)
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic              sclk_in,
  input  logic              mosi_in,
  input  logic              cs_n_in,
  input  logic              cpol_in,
  input  logic              clr_flags,
  input  logic              sample_ready,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_chan,
  output logic              frame_err,
  output logic              overflow
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [CH_W-1:0] LAST_CHAN = CH_W'(CHANNELS - 1);
`ifdef SPI_AUDIO_RX_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = 1 + 0 * FIFO_DEPTH;
`endif

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  rx_state_e              state_q, state_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]        chan_q, chan_d;
  logic                   cpol_q, cpol_d;
  logic [DATA_W-1:0]      shift_q, shift_d, shifted;
  logic                   frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic                   sclk_s, mosi_s, cs_s, cs_fall, cs_rise, sample_edge;
  logic                   push, pop, buf_full, buf_empty;
  logic [CH_W+DATA_W-1:0] head;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    cs_fall     = cs_prev_q & ~cs_s;
    cs_rise     = ~cs_prev_q & cs_s;
    sample_edge = cpol_q ? (sclk_prev_q & ~sclk_s) : (~sclk_prev_q & sclk_s);
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    chan_d      = chan_q;
    cpol_d      = cpol_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    shifted     = {shift_q[DATA_W-2:0], mosi_s};
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = RECEIVING;
          bit_cnt_d = '0;
          chan_d    = '0;
          cpol_d    = cpol_in;
          shift_d   = '0;
        end
      end
      RECEIVING: begin
        // Deselect takes priority over a sampling edge arriving in the same cycle.
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sample_edge) begin
          shift_d = shifted;
          if (bit_cnt_q == LAST_BIT) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            chan_d    = (chan_q == LAST_CHAN) ? '0 : chan_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop          = !buf_empty && sample_ready;
  assign sample_valid = !buf_empty;
  assign sample_chan  = head[CH_W+DATA_W-1:DATA_W];
  assign sample_data  = head[DATA_W-1:0];
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;

  always_comb begin
    overflow_d = overflow_q;
    if (push && buf_full && !pop) overflow_d = 1'b1;
    else if (clr_flags)           overflow_d = 1'b0;
  end

  comm_rx_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk_25mhz),
    .rst_n     (reset_n),
    .push      (push),
    .push_data ({chan_q, shifted}),
    .pop       (pop),
    .head_data (head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // cs_n synchroniser resets low so a frame already in progress at reset release
  // produces no falling edge until the line has been seen high.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      chan_q      <= '0;
      cpol_q      <= 1'b0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      chan_q      <= chan_d;
      cpol_q      <= cpol_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_spi_audio_rx.sv
// Directed bench for spi_audio_rx: default 16-bit/2-channel instance plus a
// 24-bit/1-channel instance sharing the same serial bus.
module tb_spi_audio_rx;

  localparam int HALF = 4;
`ifdef SPI_AUDIO_RX_FIFO_EN
  localparam int BUF_DEPTH = 4;
`else
  localparam int BUF_DEPTH = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, sclk, mosi, cs_n, cpol, clr_flags, ready, ready2, bus_pol;
  logic valid, ferr, ovf, valid2, ferr2, ovf2;
  logic [15:0] data;
  logic [23:0] data2;
  logic [0:0]  chan, chan2;

  int total = 0;
  int bad   = 0;
  logic [15:0] got_data[$];
  int          got_chan[$];
  logic [23:0] got2_data[$];
  int          got2_chan[$];
  int          ferr_cnt, ferr2_cnt;

  spi_audio_rx dut (
    .clk_25mhz(clk), .reset_n(reset_n), .sclk_in(sclk), .mosi_in(mosi), .cs_n_in(cs_n),
    .cpol_in(cpol), .clr_flags(clr_flags), .sample_ready(ready), .sample_valid(valid),
    .sample_data(data), .sample_chan(chan), .frame_err(ferr), .overflow(ovf)
  );

  spi_audio_rx #(.DATA_W(24), .CHANNELS(1)) dut2 (
    .clk_25mhz(clk), .reset_n(reset_n), .sclk_in(sclk), .mosi_in(mosi), .cs_n_in(cs_n),
    .cpol_in(cpol), .clr_flags(clr_flags), .sample_ready(ready2), .sample_valid(valid2),
    .sample_data(data2), .sample_chan(chan2), .frame_err(ferr2), .overflow(ovf2)
  );

  // Log every accepted sample and every frame_err cycle, sampled mid-period.
  always @(negedge clk) begin
    if (valid && ready) begin
      got_data.push_back(data);
      got_chan.push_back(int'(chan));
    end
    if (valid2 && ready2) begin
      got2_data.push_back(data2);
      got2_chan.push_back(int'(chan2));
    end
    if (ferr)  ferr_cnt++;
    if (ferr2) ferr2_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_data.delete();
    got_chan.delete();
    got2_data.delete();
    got2_chan.delete();
    ferr_cnt  = 0;
    ferr2_cnt = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; cpol = 1'b0; bus_pol = 1'b0;
    clr_flags = 1'b0; ready = 1'b1; ready2 = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    clear_logs();
  endtask

  task automatic frame_start(input logic pol);
    bus_pol = pol; cpol = pol; sclk = pol;
    tick(HALF);
    cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = w[i];
      tick(HALF);
      sclk = ~bus_pol;
      tick(HALF);
      sclk = bus_pol;
    end
  endtask

  task automatic frame_end();
    tick(HALF);
    cs_n = 1'b1;
    tick(2 * HALF + 4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; cpol = 1'b0; bus_pol = 1'b0;
    clr_flags = 1'b0; ready = 1'b1; ready2 = 1'b1;
    tick(2);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
    total++; if (data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h expected 0000", data); end
    total++; if (chan !== 1'b0) begin bad++; $display("FAIL reset_chan: got %b expected 0", chan); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b expected 0", ferr); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", ovf); end
    total++; if (valid2 !== 1'b0) begin bad++; $display("FAIL reset_valid2: got %b expected 0", valid2); end
    reset_n = 1'b1;
    tick(3);
    clear_logs();
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [2] = '{16'hA5C3, 16'h1234};
    do_reset();
    frame_start(1'b0);
    send_bits(32'hA5C3, 16);
    send_bits(32'h1234, 16);
    frame_end();
    total++; if (got_data.size() != 2) begin bad++; $display("FAIL basic_count: got %0d expected 2", got_data.size()); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_chan[i] != i) begin
        bad++;
        $display("FAIL basic_word%0d: got %h/ch%0d expected %h/ch%0d", i,
                 (i < got_data.size()) ? got_data[i] : 16'hxxxx,
                 (i < got_chan.size()) ? got_chan[i] : -1, exp_d[i], i);
      end
    end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_overflow: got %b expected 0", ovf); end
    total++; if (ferr_cnt != 0) begin bad++; $display("FAIL basic_frame_err: got %0d pulses expected 0", ferr_cnt); end
  endtask

  task automatic test_chan_wrap();
    logic [15:0] exp_d [3] = '{16'h0001, 16'h8000, 16'hBEEF};
    int          exp_c [3] = '{0, 1, 0};
    do_reset();
    frame_start(1'b0);
    for (int i = 0; i < 3; i++) send_bits({16'h0, exp_d[i]}, 16);
    frame_end();
    total++; if (got_data.size() != 3) begin bad++; $display("FAIL wrap_count: got %0d expected 3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_chan[i] != exp_c[i]) begin
        bad++;
        $display("FAIL wrap_word%0d: got %h/ch%0d expected %h/ch%0d", i,
                 (i < got_data.size()) ? got_data[i] : 16'hxxxx,
                 (i < got_chan.size()) ? got_chan[i] : -1, exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_cpol1_wide();
    logic [23:0] exp_d [4] = '{24'hABCDEF, 24'h123456, 24'h654321, 24'hFEDCBA};
    do_reset();
    frame_start(1'b1);
    send_bits({8'h0, exp_d[0]}, 24);
    frame_end();
    total++; if (got2_data.size() != 1) begin bad++; $display("FAIL cpol1_count1: got %0d expected 1", got2_data.size()); end
    frame_start(1'b1);
    cpol = 1'b0;
    for (int i = 1; i < 4; i++) send_bits({8'h0, exp_d[i]}, 24);
    frame_end();
    total++; if (got2_data.size() != 4) begin bad++; $display("FAIL cpol1_count4: got %0d expected 4", got2_data.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got2_data.size() || got2_data[i] !== exp_d[i] || got2_chan[i] != 0) begin
        bad++;
        $display("FAIL cpol1_word%0d: got %h/ch%0d expected %h/ch0", i,
                 (i < got2_data.size()) ? got2_data[i] : 24'hxxxxxx,
                 (i < got2_chan.size()) ? got2_chan[i] : -1, exp_d[i]);
      end
    end
    total++; if (ferr2_cnt != 0) begin bad++; $display("FAIL cpol1_frame_err: got %0d expected 0", ferr2_cnt); end
  endtask

  task automatic test_frame_err();
    do_reset();
    frame_start(1'b0);
    send_bits(32'h1FF, 9);
    frame_end();
    total++; if (ferr_cnt != 1) begin bad++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt); end
    total++; if (got_data.size() != 0) begin bad++; $display("FAIL ferr_no_sample: got %0d expected 0", got_data.size()); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL ferr_released: got %b expected 0", ferr); end
    frame_start(1'b0);
    send_bits(32'h5A5A, 16);
    frame_end();
    total++;
    if (got_data.size() != 1 || got_data[0] !== 16'h5A5A || got_chan[0] != 0) begin
      bad++;
      $display("FAIL ferr_next_frame: got %0d words first %h expected 1 word 5a5a/ch0",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 16'hxxxx);
    end
    total++; if (ferr_cnt != 1) begin bad++; $display("FAIL ferr_after_good: got %0d expected 1", ferr_cnt); end
  endtask

  task automatic test_overflow();
    logic [15:0] words [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    do_reset();
    ready = 1'b0;
    frame_start(1'b0);
    for (int i = 0; i < BUF_DEPTH; i++) send_bits({16'h0, words[i]}, 16);
    tick(HALF);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_at_full: got %b expected 0", ovf); end
    for (int i = BUF_DEPTH; i < BUF_DEPTH + 2; i++) send_bits({16'h0, words[i]}, 16);
    frame_end();
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b expected 1", valid); end
    total++;
    if (data !== words[0] || chan !== 1'b0) begin
      bad++; $display("FAIL ovf_head_held: got %h/ch%0d expected %h/ch0", data, chan, words[0]);
    end
    ready = 1'b1;
    tick(BUF_DEPTH + 3);
    total++; if (got_data.size() != BUF_DEPTH) begin bad++; $display("FAIL ovf_drain_count: got %0d expected %0d", got_data.size(), BUF_DEPTH); end
    for (int i = 0; i < BUF_DEPTH; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== words[i] || got_chan[i] != (i % 2)) begin
        bad++;
        $display("FAIL ovf_drain%0d: got %h/ch%0d expected %h/ch%0d", i,
                 (i < got_data.size()) ? got_data[i] : 16'hxxxx,
                 (i < got_chan.size()) ? got_chan[i] : -1, words[i], i % 2);
      end
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    tick(1);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared: got %b expected 0", ovf); end
  endtask

  task automatic test_reset_midword();
    do_reset();
    ready = 1'b0;
    frame_start(1'b0);
    send_bits(32'h8001, 16);
    tick(HALF);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b expected 1", valid); end
    send_bits(32'h16, 5);
    reset_n = 1'b0;
    tick(2);
    total++;
    if (valid !== 1'b0 || data !== 16'h0 || chan !== 1'b0 || ferr !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL rst_outputs: got v=%b d=%h c=%b fe=%b ov=%b expected all 0", valid, data, chan, ferr, ovf);
    end
    reset_n = 1'b1;
    tick(2);
    ready = 1'b1;
    send_bits(32'h7FF, 11);
    send_bits(32'h7777, 16);
    frame_end();
    total++; if (got_data.size() != 0) begin bad++; $display("FAIL rst_ignored_frame: got %0d words expected 0", got_data.size()); end
    total++; if (ferr_cnt != 0) begin bad++; $display("FAIL rst_no_frame_err: got %0d expected 0", ferr_cnt); end
    frame_start(1'b0);
    send_bits(32'h0F0F, 16);
    frame_end();
    total++;
    if (got_data.size() != 1 || got_data[0] !== 16'h0F0F || got_chan[0] != 0) begin
      bad++;
      $display("FAIL rst_next_frame: got %0d words first %h expected 1 word 0f0f/ch0",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chan_wrap();
    test_cpol1_wide();
    test_frame_err();
    test_overflow();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_audio_rx.md
# spi_audio_rx

Parametrised multi-channel serial audio receiver for the FPGA side of the Pico link. Samples a Pico-driven SCLK/MOSI/CS_n bus in the clk_25mhz domain and deserialises MSB-first words of DATA_W bits, tagging each with a channel index. Buffers completed samples in a small FIFO behind a valid/ready handshake so the downstream audio path can stall without losing words. Supersedes the fixed 16-bit single-channel receiver.

## Interface
- DATA_W, 16: bits per sample word; 8..32.
- CHANNELS, 2: words per frame before channel index wraps; 1..8.
- FIFO_DEPTH, 4: output buffer entries; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on sclk_in, mosi_in, cs_n_in; ≥2.
- clk_25mhz  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sclk_in  in  1  serial clock from Pico; asynchronous.
- mosi_in  in  1  serial data from Pico; asynchronous.
- cs_n_in  in  1  frame select from Pico, active-low; asynchronous.
- cpol_in  in  1  0: sample on SCLK rising edge; 1: sample on falling edge. Latched at frame start.
- clr_flags  in  1  one-cycle pulse clears sticky overflow.
- sample_ready  in  1  downstream accepts sample this cycle.
- sample_valid  out  1  head of FIFO valid.
- sample_data  out  DATA_W  head sample, MSB first as received.
- sample_chan  out  CH_W  channel index of head sample; CH_W = max(1, clog2(CHANNELS)).
- frame_err  out  1  one-cycle pulse: CS_n deasserted mid-word.
- overflow  out  1  sticky: a word was dropped because FIFO was full.

## Operation
- States IDLE, RECEIVING.
- IDLE: on synchronised cs_n falling edge -> RECEIVING; bit_cnt=0, chan=0, cpol latched, shift register cleared.
- RECEIVING: on each detected sampling edge of synchronised sclk, shift in synchronised mosi at LSB. When bit_cnt reaches DATA_W-1 on a sampling edge: push {chan, completed word} to FIFO, bit_cnt=0, chan = chan+1 wrapping CHANNELS-1 -> 0 (continuous frames permitted).
- RECEIVING, synchronised cs_n rises: -> IDLE. If bit_cnt≠0, partial word discarded, frame_err pulses one cycle. Sampling edge in same cycle as cs_n rise is ignored.
- Push while FIFO full (and no pop same cycle): word dropped, overflow set. Simultaneous push and pop on full FIFO succeeds.
- clr_flags clears overflow; simultaneous new drop wins (overflow stays 1).
- Handshake: pop when sample_valid && sample_ready; sample_data/sample_chan stable while valid && !ready.
- cpol_in changes during a frame have no effect until next frame start.
- Reset (any time, incl. mid-frame): state IDLE, FIFO empty, counters 0; outputs sample_valid=0, sample_data=0, sample_chan=0, frame_err=0, overflow=0. A frame in progress at reset release is ignored until cs_n seen high then low.

## Timing
- Input path latency SYNC_STAGES+1 cycles from pin edge to edge detection.
- Final sampling edge detected in cycle N -> FIFO write in N -> sample_valid=1 at N+1 (empty FIFO).
- SCLK high and low phases each ≥ SYNC_STAGES+1 clk_25mhz periods (≤ ~4.1 MHz at defaults); MOSI stable across sampling edge by same margin. CS_n high ≥ SYNC_STAGES+1 periods between frames.
- frame_err asserted exactly one cycle, in cycle after synchronised cs_n rise detected.

## Configuration
- SPI_AUDIO_RX_FIFO_EN defined: FIFO_DEPTH-entry FIFO as above.
- Undefined: single holding register (depth 1); FIFO_DEPTH ignored; push on full with same-cycle pop still accepted, otherwise drop + overflow.

## Structure
- Package comm_pkg: state localparams (IDLE=2'd0, RECEIVING=2'd1), ch_width function, shared default constants.
- Sub-module comm_rx_fifo (parametrised width/depth, registered outputs, full/empty flags); bypassed by single register when macro undefined.

## Test plan
- Defaults, cpol=0, one frame 0xA5C3 then 0x1234, ready=1 -> samples (0xA5C3, chan 0), (0x1234, chan 1), no flags.
- cpol=1, DATA_W=24, CHANNELS=1, word 0xABCDEF -> sample 0xABCDEF chan 0; three-word frame yields chan 0 each time.
- CS_n raised after 9 bits -> frame_err single pulse, no sample; next full frame received correctly with chan 0.
- ready=0, send 6 words with FIFO_DEPTH=4 -> 4 stored in order, overflow=1; drain shows first four; clr_flags -> overflow=0.
- reset_n low mid-word then released during same frame -> all outputs 0, no sample until new CS_n fall; following frame 0x0F0F correct.
- Build without SPI_AUDIO_RX_FIFO_EN, ready=0, two words -> first held, second dropped, overflow=1.
